fifo_fwft_reader: RTL



---
 rtl/fifo_fwft_reader.sv | 73 +++++++
 1 files changed

// File: rtl/fifo_fwft_reader.sv
// First-word-fall-through read adapter for the single-clock FIFO.
// Two-entry skid buffer plus in-flight tracking hides the 1-cycle read latency.
module fifo_fwft_reader #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   input  logic                  fifo_empty_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [1:0]            level_o
);

   logic [DATA_WIDTH-1:0] r_buf0;
   logic [DATA_WIDTH-1:0] r_buf1;
   logic [1:0]            r_level;
   logic                  r_inflight;

   logic [DATA_WIDTH-1:0] w_buf0_nxt;
   logic [DATA_WIDTH-1:0] w_buf1_nxt;
   logic [1:0]            w_level_nxt;
   logic [1:0]            w_lvl_pop;
   logic [2:0]            w_occ;
   logic                  w_pop;
   logic                  w_rd_en;

   assign m_valid_o = (r_level != 2'd0);
   assign w_pop     = m_valid_o & m_ready_i;
   assign w_lvl_pop = r_level - {1'b0, w_pop};
   assign w_occ     = {1'b0, w_lvl_pop} + {2'b00, r_inflight};

   // Same-cycle pop frees a slot, so ready feeds the read strobe directly.
   assign w_rd_en = !rst & !fifo_empty_i & (w_occ < 3'd2);

   assign fifo_rd_en_o = w_rd_en;
   assign m_data_o     = r_buf0;
   assign level_o      = r_level;

   always_comb begin
      w_buf0_nxt  = r_buf0;
      w_buf1_nxt  = r_buf1;
      w_level_nxt = w_lvl_pop + {1'b0, r_inflight};
      // Head only shifts when a second word exists, so data holds once drained.
      if (w_pop && (r_level == 2'd2)) begin
         w_buf0_nxt = r_buf1;
      end
      if (r_inflight) begin
         if (w_lvl_pop == 2'd0) begin
            w_buf0_nxt = fifo_rd_data_i;
         end else begin
            w_buf1_nxt = fifo_rd_data_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf0     <= '0;
         r_buf1     <= '0;
         r_level    <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_buf0     <= w_buf0_nxt;
         r_buf1     <= w_buf1_nxt;
         r_level    <= w_level_nxt;
         r_inflight <= w_rd_en;
      end
   end

endmodule
